// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues npc to instruction memory, tracks in-flight
// requests, feeds fetched words back to the predictor and buffers {pc, inst} for decode.
module fetch_unit #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        br_late_done,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] inst_feedback,
  output logic        fetch_stall,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int unsigned PW = $clog2(MAX_INFLIGHT);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(MAX_INFLIGHT);

  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;

  logic [31:0] pq_mem    [MAX_INFLIGHT];
  logic [31:0] bpc_mem   [MAX_INFLIGHT];
  logic [31:0] binst_mem [MAX_INFLIGHT];

  logic [CW:0] credit_used;
  logic        fire;
  logic        resp_ok;
  logic        drop;
  logic        push;
  logic        pop;

  // Credit is computed from registered state only, so same-cycle pops never free a slot.
  assign credit_used    = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = !rst && (credit_used < CREDIT_MAX);
  assign imem_req_addr  = npc;
  assign fire           = imem_req_valid && imem_req_ready;
  assign fetch_stall    = !fire;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok        = !rst && imem_resp_valid && (out_q != '0);
  assign drop           = (disc_q != '0) || br_late_done;
  assign push           = resp_ok && !drop;
  assign inst_feedback  = push ? imem_resp_data : '0;

  assign dec_valid      = !rst && (cnt_q != '0);
  assign pop            = dec_valid && dec_ready;
  assign dec_pc         = dec_valid ? bpc_mem[buf_rd_q]   : '0;
  assign dec_inst       = dec_valid ? binst_mem[buf_rd_q] : '0;

  always_comb begin
    out_d    = out_q;
    disc_d   = disc_q;
    cnt_d    = cnt_q;
    pq_wr_d  = pq_wr_q;
    pq_rd_d  = pq_rd_q;
    buf_wr_d = buf_wr_q;
    buf_rd_d = buf_rd_q;

    if (fire && !resp_ok) begin
      out_d = out_q + CW'(1);
    end else if (!fire && resp_ok) begin
      out_d = out_q - CW'(1);
    end

    if (fire) begin
      pq_wr_d = pq_wr_q + PW'(1);
    end
    if (resp_ok) begin
      pq_rd_d = pq_rd_q + PW'(1);
    end

    // On a redirect everything issued before this cycle is wrong-path; the
    // request fired alongside the redirect is the new target and is kept.
    if (br_late_done) begin
      disc_d = resp_ok ? (out_q - CW'(1)) : out_q;
    end else if (resp_ok && (disc_q != '0)) begin
      disc_d = disc_q - CW'(1);
    end

    if (br_late_done) begin
      cnt_d    = '0;
      buf_rd_d = buf_wr_q;
    end else begin
      if (push && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CW'(1);
      end
      if (push) begin
        buf_wr_d = buf_wr_q + PW'(1);
      end
      if (pop) begin
        buf_rd_d = buf_rd_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      pq_wr_q  <= '0;
      pq_rd_q  <= '0;
      buf_wr_q <= '0;
      buf_rd_q <= '0;
    end else begin
      out_q    <= out_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      pq_wr_q  <= pq_wr_d;
      pq_rd_q  <= pq_rd_d;
      buf_wr_q <= buf_wr_d;
      buf_rd_q <= buf_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      pq_mem[pq_wr_q] <= imem_req_addr;
    end
    if (push) begin
      bpc_mem[buf_wr_q]   <= pq_mem[pq_rd_q];
      binst_mem[buf_wr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, memory/decode backpressure,
// late-branch flushes and a stray response, against an in-order memory model.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic [31:0] npc;
  logic        br_late_done;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] inst_feedback;
  logic        fetch_stall;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;

  fetch_unit #(.MAX_INFLIGHT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .npc             (npc),
    .br_late_done    (br_late_done),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_feedback   (inst_feedback),
    .fetch_stall     (fetch_stall),
    .dec_valid       (dec_valid),
    .dec_inst        (dec_inst),
    .dec_pc          (dec_pc),
    .dec_ready       (dec_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          lat     = 1;
  int          fires   = 0;
  int          pops    = 0;
  logic [31:0] nxt     = '0;
  logic [31:0] exp_pc  = '0;
  bit          mon_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive this cycle's memory response, then let combinational outputs settle.
  task automatic settle();
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq[0].addr ^ K;
    end
    #1;
  endtask

  task automatic tick();
    req_t r;
    if (mon_en && dec_valid && dec_ready) begin
      check("dec_pc_seq", dec_pc, exp_pc);
      check("dec_inst_seq", dec_inst, exp_pc ^ K);
      exp_pc = exp_pc + 32'd4;
    end
    if (dec_valid && dec_ready) pops++;
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr;
      r.due  = cyc + lat;
      mq.push_back(r);
      fires++;
      nxt = imem_req_addr + 32'd4;
    end
    if (imem_resp_valid && mq.size() > 0) void'(mq.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b1;
    settle();
    while ((mq.size() > 0 || dec_valid) && k < 20) begin
      tick();
      settle();
      k++;
    end
    check("drain_bound", 32'(k < 20), 32'd1);
    check("drain_count", pops, fires);
  endtask

  initial begin
    rst             = 1'b1;
    npc             = '0;
    br_late_done    = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    dec_ready       = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      settle();
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_stall", fetch_stall, 1);
      check("rst_dec_valid", dec_valid, 0);
      check("rst_dec_pc", dec_pc, 0);
      check("rst_dec_inst", dec_inst, 0);
      check("rst_feedback", inst_feedback, 0);
      tick();
    end
    rst = 1'b0;

    // Streaming with 1-cycle memory
    mon_en = 1'b1;
    exp_pc = '0;
    for (int c = 0; c < 10; c++) begin
      npc = nxt;
      settle();
      check("stream_stall", fetch_stall, 0);
      if (c == 0) begin
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, 0);
      end
      if (c >= 1) check("stream_feedback", inst_feedback, (32'(c - 1) * 32'd4) ^ K);
      if (c >= 2) begin
        check("stream_dec_valid", dec_valid, 1);
        check("stream_dec_pc", dec_pc, 32'(c - 2) * 32'd4);
      end
      tick();
    end

    // Memory backpressure
    begin
      int f0;
      f0 = fires;
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        npc = nxt;
        settle();
        check("membp_stall", fetch_stall, 1);
        tick();
      end
      check("membp_no_push", fires, f0);
      imem_req_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
        npc = nxt;
        settle();
        check("membp_resume_stall", fetch_stall, 0);
        tick();
      end
      drain();
    end

    // Decode backpressure
    dec_ready      = 1'b0;
    imem_req_ready = 1'b1;
    for (int a = 0; a < 6; a++) begin
      npc = nxt;
      settle();
      if (a < 4) begin
        check("decbp_fire_stall", fetch_stall, 0);
      end else begin
        check("decbp_req_valid", imem_req_valid, 0);
        check("decbp_stall", fetch_stall, 1);
        check("decbp_dec_valid", dec_valid, 1);
        check("decbp_head_pc", dec_pc, exp_pc);
      end
      tick();
    end
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      npc = nxt;
      settle();
      tick();
    end
    drain();

    // Stray response with nothing outstanding
    imem_req_ready = 1'b0;
    settle();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    #1;
    check("stray_feedback", inst_feedback, 0);
    tick();
    settle();
    check("stray_dec_valid", dec_valid, 0);
    check("stray_req_valid", imem_req_valid, 1);
    mon_en = 1'b0;

    // Flush with two requests outstanding, 2-cycle memory
    lat = 2;
    imem_req_ready = 1'b1;
    npc = 32'h10;
    settle();
    check("fl1_stall0", fetch_stall, 0);
    tick();
    npc = 32'h14;
    settle();
    tick();
    npc = 32'h200;
    br_late_done = 1'b1;
    settle();
    check("fl1_resp_present", imem_resp_valid, 1);
    check("fl1_fb_drop10", inst_feedback, 0);
    check("fl1_stall_target", fetch_stall, 0);
    tick();
    br_late_done   = 1'b0;
    imem_req_ready = 1'b0;
    npc = '0;
    settle();
    check("fl1_fb_drop14", inst_feedback, 0);
    check("fl1_dec_empty", dec_valid, 0);
    tick();
    settle();
    check("fl1_fb_target", inst_feedback, 32'h200 ^ K);
    check("fl1_dec_empty2", dec_valid, 0);
    tick();
    settle();
    check("fl1_dec_valid", dec_valid, 1);
    check("fl1_dec_pc", dec_pc, 32'h200);
    check("fl1_dec_inst", dec_inst, 32'h200 ^ K);
    tick();
    settle();
    check("fl1_idle_dec", dec_valid, 0);
    check("fl1_idle_req", imem_req_valid, 1);

    // Flush coincident with the 0x14 response
    imem_req_ready = 1'b1;
    npc = 32'h10;
    settle();
    tick();
    npc = 32'h14;
    settle();
    tick();
    imem_req_ready = 1'b0;
    settle();
    check("fl2_fb_keep10", inst_feedback, 32'h10 ^ K);
    tick();
    imem_req_ready = 1'b1;
    br_late_done   = 1'b1;
    npc = 32'h200;
    settle();
    check("fl2_fb_drop14", inst_feedback, 0);
    check("fl2_head_valid", dec_valid, 1);
    check("fl2_head_pc", dec_pc, 32'h10);
    check("fl2_stall_target", fetch_stall, 0);
    tick();
    br_late_done   = 1'b0;
    imem_req_ready = 1'b0;
    settle();
    check("fl2_dec_flushed", dec_valid, 0);
    check("fl2_fb_none", inst_feedback, 0);
    tick();
    settle();
    check("fl2_fb_target", inst_feedback, 32'h200 ^ K);
    tick();
    settle();
    check("fl2_dec_valid", dec_valid, 1);
    check("fl2_dec_pc", dec_pc, 32'h200);
    tick();
    settle();
    check("fl2_idle_dec", dec_valid, 0);
    check("fl2_idle_req", imem_req_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
